mac_array_ctrl: RTL and testbench

Sequencer for the row×col grid of mac_tile processing elements. On a start pulse it runs a kernel-load phase, a settle gap, an execute phase of programmable length, and a drain phase. It drives the 2-bit west-edge instruction of every array row, with a one-cycle skew per row, and pops the L0 input buffer in lock-step with row 0. Empty-buffer stalls are absorbed as instruction bubbles, because the array itself has no stall input.

---
 rtl/mac_array_ctrl.sv | 153 +++++++++++++++
 tb/tb_mac_array_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: load / gap / execute / drain sequencer for the mac_tile grid.
// Row 0 gets its instruction combinationally; rows 1..row-1 see it through a
// one-cycle-per-row skew chain. Empty L0 cycles become bubbles because the
// array has no stall input of its own.
//
// state | meaning
// IDLE  | waiting for start, exec_len captured on accept
// LOAD  | col kernel-load slots, one L0 pop per slot
// GAP   | col quiet cycles so the kernel settles across the array
// EXEC  | len_q execute slots, one L0 pop per slot
// DRAIN | row+col-1 quiet cycles so the last psum leaves the south edge
// DONE  | single-cycle done pulse
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] exec_len,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [2*row-1:0]  inst_w,
  output logic              busy,
  output logic              done
);

  localparam int w_col = $clog2(col + 1);
  localparam int w_drn = $clog2(row + col);
  localparam int w_ab  = (len_bw > w_col) ? len_bw : w_col;
  localparam int cnt_w = (w_ab > w_drn) ? w_ab : w_drn;

  localparam logic [cnt_w-1:0] col_t = cnt_w'(col);
  localparam logic [cnt_w-1:0] drn_t = cnt_w'(row + col - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d, cnt_inc, len_t;
  logic [len_bw-1:0] len_q;
  logic [1:0]        inst0;

  assign cnt_inc = cnt_q + cnt_w'(1);
  assign len_t   = cnt_w'(len_q);

  // State, counter and latched execute length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) len_q <= exec_len;
    end
  end

  // Next state, counter update and row-0 instruction / L0 pop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst0   = 2'b00;
    l0_rd   = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (!l0_empty) begin
          inst0 = 2'b01;
          l0_rd = 1'b1;
          if (cnt_inc == col_t) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      GAP: begin
        if (cnt_inc == col_t) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? DRAIN : EXEC;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      EXEC: begin
        if (!l0_empty) begin
          inst0 = 2'b10;
          l0_rd = 1'b1;
          if (cnt_inc == len_t) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DRAIN: begin
        if (cnt_inc == drn_t) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  generate
    if (row > 1) begin : g_skew
      logic [2*(row-1)-1:0] sk_q;

      // Skew chain: row r holds the row-0 instruction from r cycles ago.
      always_ff @(posedge clk) begin
        if (reset) begin
          sk_q <= '0;
        end else begin
          sk_q[1:0] <= inst0;
          for (int r = 1; r < row - 1; r++) begin
            sk_q[2*r +: 2] <= sk_q[2*(r-1) +: 2];
          end
        end
      end

      assign inst_w = {sk_q, inst0};
    end else begin : g_noskew
      assign inst_w = inst0;
    end
  endgenerate

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: scenario table with spec-derived totals, a few
// hand-picked cycle checks, and random traffic against a token-queue model.
module tb_mac_array_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LBW = 8;

  localparam int T_LOAD  = 1;
  localparam int T_GAP   = 2;
  localparam int T_EXEC  = 3;
  localparam int T_DRAIN = 4;
  localparam int T_DONE  = 5;

  logic             clk = 1'b0;
  logic             reset, start, l0_empty;
  logic [LBW-1:0]   exec_len;
  logic             l0_rd, busy, done;
  logic [2*ROW-1:0] inst_w;

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk(clk), .reset(reset), .start(start), .exec_len(exec_len),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst_w(inst_w), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending work as a token queue, one token per cycle of
  // work; slot tokens are held back by an empty L0. Skew is a history of row 0.
  int q[$];
  logic [1:0] hist [ROW];
  logic [1:0] exp_r0;
  logic [2*ROW-1:0] exp_w;
  logic exp_rd, exp_busy, exp_done;

  int pops, loads, execs, dones, first_done;
  logic [1:0] r7_at7, r7_at8, r7_at24;
  logic [2*ROW+1:0] snap19;

  task automatic model_expect(input logic le);
    exp_r0 = 2'b00; exp_rd = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    if (q.size() != 0) begin
      exp_busy = 1'b1;
      if (q[0] == T_LOAD && !le) begin exp_r0 = 2'b01; exp_rd = 1'b1; end
      if (q[0] == T_EXEC && !le) begin exp_r0 = 2'b10; exp_rd = 1'b1; end
      if (q[0] == T_DONE) exp_done = 1'b1;
    end
    exp_w[1:0] = exp_r0;
    for (int r = 1; r < ROW; r++) exp_w[2*r +: 2] = hist[r];
  endtask

  task automatic model_advance(input logic st, input logic rs, input logic le,
                               input logic [LBW-1:0] ln);
    bit idle;
    if (rs) begin
      q.delete();
      for (int r = 0; r < ROW; r++) hist[r] = 2'b00;
    end else begin
      idle = (q.size() == 0);
      if (!idle) begin
        if (!((q[0] == T_LOAD || q[0] == T_EXEC) && le)) void'(q.pop_front());
      end
      for (int r = ROW - 1; r >= 2; r--) hist[r] = hist[r-1];
      hist[1] = exp_r0;
      if (idle && st) begin
        for (int i = 0; i < COL; i++) q.push_back(T_LOAD);
        for (int i = 0; i < COL; i++) q.push_back(T_GAP);
        for (int i = 0; i < int'(ln); i++) q.push_back(T_EXEC);
        for (int i = 0; i < ROW + COL - 1; i++) q.push_back(T_DRAIN);
        q.push_back(T_DONE);
      end
    end
  endtask

  task automatic step(input logic st, input logic rs, input logic le,
                      input logic [LBW-1:0] ln, input string tag, input int cyc);
    start = st; reset = rs; l0_empty = le; exec_len = ln;
    @(negedge clk);
    model_expect(le);
    checks++;
    if ({inst_w, l0_rd, busy, done} !== {exp_w, exp_rd, exp_busy, exp_done}) begin
      errors++;
      $display("FAIL %s cycle %0d: got inst_w=%h rd=%b busy=%b done=%b, want inst_w=%h rd=%b busy=%b done=%b",
               tag, cyc, inst_w, l0_rd, busy, done, exp_w, exp_rd, exp_busy, exp_done);
    end
    if (l0_rd) pops++;
    if (inst_w[1:0] == 2'b01) loads++;
    if (inst_w[1:0] == 2'b10) execs++;
    if (done) begin
      dones++;
      if (first_done < 0) first_done = cyc;
    end
    if (cyc == 7)  r7_at7  = inst_w[2*ROW-1 -: 2];
    if (cyc == 8)  r7_at8  = inst_w[2*ROW-1 -: 2];
    if (cyc == 24) r7_at24 = inst_w[2*ROW-1 -: 2];
    if (cyc == 19) snap19  = {inst_w, l0_rd, busy};
    model_advance(st, rs, le, ln);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  typedef struct {
    string name;
    int    len;
    int    stl0, stl1, stl2;
    int    rst_cyc;
    int    st1, st2;
    int    exp_first_done, exp_dones, exp_pops, exp_loads, exp_execs;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"nominal", 4, -1, -1, -1, -1, -1, -1, 36, 1, 12,  8, 4};
    tbl[1] = '{"stall",   4,  3,  4, 20, -1, -1, -1, 39, 1, 12,  8, 4};
    tbl[2] = '{"zerolen", 0, -1, -1, -1, -1, -1, -1, 32, 1,  8,  8, 0};
    tbl[3] = '{"rstexec", 4, -1, -1, -1, 18, 20, -1, 56, 1, 22, 16, 6};
    tbl[4] = '{"busyst",  4, -1, -1, -1, -1,  5, 36, 36, 1, 12,  8, 4};

    for (int r = 0; r < ROW; r++) hist[r] = 2'b00;
    start = 1'b0; reset = 1'b1; l0_empty = 1'b0; exec_len = '0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      first_done = -1;
      step(1'b0, 1'b1, 1'b0, '0, "reset", -1);
      step(1'b0, 1'b1, 1'b0, '0, "reset", -1);
      pops = 0; loads = 0; execs = 0; dones = 0; first_done = -1;
      r7_at7 = 2'bxx; r7_at8 = 2'bxx; r7_at24 = 2'bxx; snap19 = 'x;
      for (int c = 0; c < 64; c++) begin
        logic st, rs, le;
        logic [LBW-1:0] ln;
        st = (c == 0) || (c == tbl[v].st1) || (c == tbl[v].st2);
        rs = (c == tbl[v].rst_cyc);
        le = (c == tbl[v].stl0) || (c == tbl[v].stl1) || (c == tbl[v].stl2);
        ln = st ? LBW'(tbl[v].len) : LBW'($urandom_range(0, 255));
        step(st, rs, le, ln, tbl[v].name, c);
      end
      cmp({tbl[v].name, " first_done"}, first_done, tbl[v].exp_first_done);
      cmp({tbl[v].name, " dones"},      dones,      tbl[v].exp_dones);
      cmp({tbl[v].name, " pops"},       pops,       tbl[v].exp_pops);
      cmp({tbl[v].name, " loads"},      loads,      tbl[v].exp_loads);
      cmp({tbl[v].name, " execs"},      execs,      tbl[v].exp_execs);
      if (v == 0) begin
        cmp("row7 cycle7",  int'(r7_at7),  0);
        cmp("row7 cycle8",  int'(r7_at8),  1);
        cmp("row7 cycle24", int'(r7_at24), 2);
      end
      if (v == 3) cmp("after reset cycle19", int'(snap19 != '0), 0);
    end

    // Random traffic, including resets and starts at arbitrary points.
    step(1'b0, 1'b1, 1'b0, '0, "reset", -1);
    for (int c = 0; c < 3000; c++) begin
      logic st, rs, le;
      logic [LBW-1:0] ln;
      st = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 255) == 0);
      le = ($urandom_range(0, 3) == 0);
      ln = ($urandom_range(0, 7) == 0) ? LBW'(0) : LBW'($urandom_range(1, 12));
      step(st, rs, le, ln, "random", c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
